// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU among NREQ requesters.
// A round-robin arbiter grants one requester at a time, registers its operands and
// control into the ALU, captures the result and flags one cycle later, and returns
// them tagged with the requester index over a valid/ready response channel.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           per-requester handshake (ready is one-hot, combinational)
//   req_a/req_b/req_control       packed per-requester operands and ALU control
//   alu_a/alu_b/alu_control       registered operands/control driven into the ALU
//   alu_result/alu_c_out/
//   alu_zero/alu_negative         ALU outputs, captured in EXEC
//   rsp_valid/rsp_ready           response handshake
//   rsp_id/rsp_result/rsp_c_out/
//   rsp_zero/rsp_negative         captured response, tagged with the served index
//   busy                          high while an operation is in EXEC or RESP
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_control,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [1:0]            alu_control,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_c_out,
    input  logic                  alu_zero,
    input  logic                  alu_negative,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_c_out,
    output logic                  rsp_zero,
    output logic                  rsp_negative,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [1:0]       alu_control_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_c_out_q, rsp_zero_q, rsp_negative_q;
    logic             busy_q;

    // Round-robin pick: lowest valid index at or above the pointer wins; if none,
    // the lowest valid index overall wins (the wrap-around case).
    logic             any_lo, any_hi;
    logic [IDW-1:0]   lo_idx, hi_idx;
    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   ptr_next;

    always_comb begin
        any_lo = 1'b0;
        any_hi = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        // Descending scan so the last hit is the lowest index.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_lo = 1'b1;
                lo_idx = IDW'(i);
                if (32'(i) >= 32'(ptr_q)) begin
                    any_hi = 1'b1;
                    hi_idx = IDW'(i);
                end
            end
        end
        grant_vld = any_lo;
        grant_idx = any_hi ? hi_idx : lo_idx;
        ptr_next  = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
    end

    // Operand mux and one-hot accept strobe for the granted requester.
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [1:0]       sel_control;

    always_comb begin
        sel_a       = '0;
        sel_b       = '0;
        sel_control = '0;
        req_ready   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a        = req_a[i*WIDTH +: WIDTH];
                sel_b        = req_b[i*WIDTH +: WIDTH];
                sel_control  = req_control[i*2 +: 2];
                req_ready[i] = (state_q == StIdle) && grant_vld;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            ptr_q          <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_control_q  <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_c_out_q    <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_negative_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        alu_a_q       <= sel_a;
                        alu_b_q       <= sel_b;
                        alu_control_q <= sel_control;
                        rsp_id_q      <= grant_idx;
                        ptr_q         <= ptr_next;
                        busy_q        <= 1'b1;
                        state_q       <= StExec;
                    end
                end
                StExec: begin
                    rsp_result_q   <= alu_result;
                    rsp_c_out_q    <= alu_c_out;
                    rsp_zero_q     <= alu_zero;
                    rsp_negative_q <= alu_negative;
                    rsp_valid_q    <= 1'b1;
                    state_q        <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_control  = alu_control_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_c_out    = rsp_c_out_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_negative = rsp_negative_q;
    assign busy         = busy_q;

endmodule
